// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, runs a one-outstanding req/rvalid fetch to imem.
// Optional macro FETCH_MISALIGN_CHECK_EN adds a sticky fault on misaligned redirect targets.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF,
  output logic        MisalignF
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {FETCH, HOLD, DROP, FAULT} state_t;
`else
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q;
  logic [31:0] fetchPc_q;
  logic [31:0] dropAddr_q;
  logic [31:0] holdBuf_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pcPlus4_q;
  logic        valid_q;
  logic [31:0] pcNext_d;
  logic [31:0] target_d;

  // While dropping, the abandoned request keeps its original address until it returns.
  assign imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr = (state_q == DROP) ? dropAddr_q : fetchPc_q;
  assign pcNext_d  = fetchPc_q + 32'd4;

  assign InstrF   = instr_q;
  assign PCF      = pc_q;
  assign PCPlus4F = pcPlus4_q;
  assign ValidF   = valid_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  assign target_d  = PCTargetE;
  assign MisalignF = misalign_q;
`else
  logic unusedTgtBits;
  assign unusedTgtBits = ^PCTargetE[1:0];
  assign target_d  = {PCTargetE[31:2], 2'b00};
  assign MisalignF = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      fetchPc_q  <= RESET_PC;
      dropAddr_q <= RESET_PC;
      holdBuf_q  <= NOP;
      instr_q    <= NOP;
      pc_q       <= 32'h0;
      pcPlus4_q  <= 32'h0;
      valid_q    <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else if (PCSrcE) begin
      // Redirect beats stall; an in-flight request with no response yet must be drained in DROP.
      fetchPc_q  <= target_d;
      instr_q    <= NOP;
      valid_q    <= 1'b0;
      holdBuf_q  <= NOP;
      dropAddr_q <= imem_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= |PCTargetE[1:0];
      if (|PCTargetE[1:0])
        state_q <= FAULT;
      else
`endif
      if (imem_req && !imem_rvalid)
        state_q <= DROP;
      else
        state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_rvalid) begin
            if (StallF) begin
              holdBuf_q <= imem_rdata;
              state_q   <= HOLD;
            end else begin
              instr_q   <= imem_rdata;
              pc_q      <= fetchPc_q;
              pcPlus4_q <= pcNext_d;
              valid_q   <= 1'b1;
              fetchPc_q <= pcNext_d;
            end
          end else if (!StallF) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!StallF) begin
            instr_q   <= holdBuf_q;
            pc_q      <= fetchPc_q;
            pcPlus4_q <= pcNext_d;
            valid_q   <= 1'b1;
            fetchPc_q <= pcNext_d;
            state_q   <= FETCH;
          end
        end
        DROP: begin
          if (imem_rvalid)
            state_q <= FETCH;
        end
        default: state_q <= state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit; memory responses are driven cycle by cycle.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ValidF;
  logic        MisalignF;

  int errors = 0;
  int checks = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .reset_n(reset_n), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF), .MisalignF(MisalignF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Drives one cycle of inputs right after a falling edge; memory only answers a live request.
  task automatic applyStimulus(input logic rv, input logic stall, input logic src,
                               input logic [31:0] tgt, input logic [31:0] dat);
    StallF      = stall;
    PCSrcE      = src;
    PCTargetE   = tgt;
    imem_rdata  = dat;
    imem_rvalid = rv & imem_req;
    @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (InstrF !== NOP) begin errors++; $display("[TB] FAIL rst_instr: got %h want %h", InstrF, NOP); end
    checks++; if (PCF !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h want %h", PCF, 32'h0); end
    checks++; if (PCPlus4F !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc4: got %h want %h", PCPlus4F, 32'h0); end
    checks++; if (ValidF !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", ValidF); end
    checks++; if (MisalignF !== 1'b0) begin errors++; $display("[TB] FAIL rst_misalign: got %b want 0", MisalignF); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL rst_addr: got %h want %h", imem_addr, 32'h100); end
  endtask

  task automatic test_zero_wait;
    logic [31:0] a;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + 32'(4 * i);
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL zw_req%0d: got %b want 1", i, imem_req); end
      checks++; if (imem_addr !== a) begin errors++; $display("[TB] FAIL zw_addr%0d: got %h want %h", i, imem_addr, a); end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(a));
      checks++; if (ValidF !== 1'b1) begin errors++; $display("[TB] FAIL zw_valid%0d: got %b want 1", i, ValidF); end
      checks++; if (PCF !== a) begin errors++; $display("[TB] FAIL zw_pc%0d: got %h want %h", i, PCF, a); end
      checks++; if (PCPlus4F !== a + 32'd4) begin errors++; $display("[TB] FAIL zw_pc4_%0d: got %h want %h", i, PCPlus4F, a + 32'd4); end
      checks++; if (InstrF !== dataOf(a)) begin errors++; $display("[TB] FAIL zw_instr%0d: got %h want %h", i, InstrF, dataOf(a)); end
    end
  endtask

  task automatic test_wait2;
    logic [31:0] a;
    for (int k = 0; k < 2; k++) begin
      a = 32'h10C + 32'(4 * k);
      for (int w = 0; w < 2; w++) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("[TB] FAIL ws_addr%0d_%0d: got req=%b addr=%h want req=1 addr=%h", k, w, imem_req, imem_addr, a); end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (ValidF !== 1'b0 || InstrF !== NOP) begin errors++; $display("[TB] FAIL ws_bubble%0d_%0d: got valid=%b instr=%h want valid=0 instr=%h", k, w, ValidF, InstrF, NOP); end
      end
      checks++; if (imem_addr !== a) begin errors++; $display("[TB] FAIL ws_addr_done%0d: got %h want %h", k, imem_addr, a); end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(a));
      checks++; if (ValidF !== 1'b1 || PCF !== a) begin errors++; $display("[TB] FAIL ws_out%0d: got valid=%b pc=%h want valid=1 pc=%h", k, ValidF, PCF, a); end
    end
  endtask

  task automatic test_stall_hold;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, dataOf(32'h114));
    checks++; if (ValidF !== 1'b0 || InstrF !== NOP) begin errors++; $display("[TB] FAIL sh_redir_out: got valid=%b instr=%h want valid=0 instr=%h", ValidF, InstrF, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL sh_redir_addr: got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr); end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL sh_wait_addr: got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr); end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, dataOf(32'h200));
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL sh_hold_req: got %b want 0", imem_req); end
    checks++; if (ValidF !== 1'b0 || InstrF !== NOP) begin errors++; $display("[TB] FAIL sh_hold_frozen: got valid=%b instr=%h want valid=0 instr=%h", ValidF, InstrF, NOP); end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL sh_hold_req2: got %b want 0", imem_req); end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (InstrF !== dataOf(32'h200)) begin errors++; $display("[TB] FAIL sh_rel_instr: got %h want %h", InstrF, dataOf(32'h200)); end
    checks++; if (PCF !== 32'h200 || PCPlus4F !== 32'h204 || ValidF !== 1'b1) begin errors++; $display("[TB] FAIL sh_rel_pc: got pc=%h pc4=%h valid=%b want 00000200 00000204 1", PCF, PCPlus4F, ValidF); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin errors++; $display("[TB] FAIL sh_next_addr: got req=%b addr=%h want req=1 addr=00000204", imem_req, imem_addr); end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checks++; if (PCF !== 32'h200 || ValidF !== 1'b1) begin errors++; $display("[TB] FAIL sh_freeze_valid: got pc=%h valid=%b want 00000200 1", PCF, ValidF); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(32'h204));
    checks++; if (PCF !== 32'h204 || InstrF !== dataOf(32'h204)) begin errors++; $display("[TB] FAIL sh_after: got pc=%h instr=%h want 00000204 %h", PCF, InstrF, dataOf(32'h204)); end
  endtask

  task automatic test_redirect_drop;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, dataOf(32'h208));
    checks++; if (imem_addr !== 32'h300) begin errors++; $display("[TB] FAIL rd_first_addr: got %h want 00000300", imem_addr); end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h400, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || ValidF !== 1'b0) begin errors++; $display("[TB] FAIL rd_drop: got req=%b addr=%h valid=%b want 1 00000300 0", imem_req, imem_addr, ValidF); end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (imem_addr !== 32'h300) begin errors++; $display("[TB] FAIL rd_drop_stable: got %h want 00000300", imem_addr); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(32'h300));
    checks++; if (ValidF !== 1'b0 || InstrF !== NOP) begin errors++; $display("[TB] FAIL rd_discard: got valid=%b instr=%h want valid=0 instr=%h", ValidF, InstrF, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin errors++; $display("[TB] FAIL rd_new_addr: got req=%b addr=%h want req=1 addr=00000400", imem_req, imem_addr); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(32'h400));
    checks++; if (PCF !== 32'h400 || ValidF !== 1'b1 || InstrF !== dataOf(32'h400)) begin errors++; $display("[TB] FAIL rd_target_out: got pc=%h valid=%b instr=%h want 00000400 1 %h", PCF, ValidF, InstrF, dataOf(32'h400)); end
  endtask

  task automatic test_redirect_stall;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h600, dataOf(32'h404));
    checks++; if (ValidF !== 1'b0 || InstrF !== NOP) begin errors++; $display("[TB] FAIL rs_nop: got valid=%b instr=%h want valid=0 instr=%h", ValidF, InstrF, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h600) begin errors++; $display("[TB] FAIL rs_addr: got req=%b addr=%h want req=1 addr=00000600", imem_req, imem_addr); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(32'h600));
    checks++; if (PCF !== 32'h600 || ValidF !== 1'b1) begin errors++; $display("[TB] FAIL rs_out: got pc=%h valid=%b want 00000600 1", PCF, ValidF); end
  endtask

  task automatic test_misalign;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h402, dataOf(32'h604));
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if (MisalignF !== 1'b1 || imem_req !== 1'b0 || ValidF !== 1'b0) begin errors++; $display("[TB] FAIL ma_fault: got mis=%b req=%b valid=%b want 1 0 0", MisalignF, imem_req, ValidF); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(32'h400));
    checks++; if (MisalignF !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL ma_sticky: got mis=%b req=%b want 1 0", MisalignF, imem_req); end
`else
    checks++; if (MisalignF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin errors++; $display("[TB] FAIL ma_forced: got mis=%b req=%b addr=%h want 0 1 00000400", MisalignF, imem_req, imem_addr); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(32'h400));
    checks++; if (PCF !== 32'h400 || ValidF !== 1'b1) begin errors++; $display("[TB] FAIL ma_forced_out: got pc=%h valid=%b want 00000400 1", PCF, ValidF); end
`endif
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h500, dataOf(32'h404));
    checks++; if (MisalignF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h500) begin errors++; $display("[TB] FAIL ma_clear: got mis=%b req=%b addr=%h want 0 1 00000500", MisalignF, imem_req, imem_addr); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(32'h500));
    checks++; if (PCF !== 32'h500 || ValidF !== 1'b1) begin errors++; $display("[TB] FAIL ma_out: got pc=%h valid=%b want 00000500 1", PCF, ValidF); end
  endtask

  task automatic test_wrap;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, dataOf(32'h504));
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wr_addr: got %h want fffffffc", imem_addr); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(32'hFFFF_FFFC));
    checks++; if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin errors++; $display("[TB] FAIL wr_pc: got pc=%h pc4=%h want fffffffc 00000000", PCF, PCPlus4F); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wr_next: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_reset_mid;
    imem_rvalid = 1'b0;
    StallF      = 1'b0;
    PCSrcE      = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ValidF !== 1'b0 || InstrF !== NOP || PCF !== 32'h0) begin errors++; $display("[TB] FAIL rm_async: got valid=%b instr=%h pc=%h want 0 %h 00000000", ValidF, InstrF, PCF, NOP); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL rm_addr: got %h want 00000100", imem_addr); end
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, dataOf(32'h100));
    checks++; if (PCF !== 32'h100 || ValidF !== 1'b1) begin errors++; $display("[TB] FAIL rm_refetch: got pc=%h valid=%b want 00000100 1", PCF, ValidF); end
  endtask

  initial begin
    reset_n     = 1'b1;
    StallF      = 1'b0;
    PCSrcE      = 1'b0;
    PCTargetE   = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_zero_wait;
    test_wait2;
    test_stall_hold;
    test_redirect_drop;
    test_redirect_stall;
    test_misalign;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
